// File: rtl/ppu_pkg.sv
// ppu_pkg: shared posit-unit types, defaults and width helpers
`ifndef N
`define N 16
`endif
package ppu_pkg;
  localparam int ES = 1;
  localparam int NR_ITERS = 2;
`ifdef PIPELINE_STAGE
  localparam int NR_LAT_DEF = 1;
`else
  localparam int NR_LAT_DEF = 0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} nr_state_t;
  function automatic int mant_size(input int n);
    return n - ES - 1;
  endfunction
endpackage

// File: rtl/nr_sequencer_newton_raphson.sv
// newton_raphson: one reciprocal refinement step x1 = x*(2 - num*x), optionally registered
module newton_raphson #(
  parameter int MS = 14,
  parameter int NR_LAT = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [MS-1:0]   num_i,
  input  logic [3*MS-5:0] x_i,
  output logic [2*MS-1:0] x1_o
);
  localparam logic [4*MS-5:0] TWO = {2'b10, {(4*MS-6){1'b0}}};
  logic [4*MS-5:0] prod, corr;
  logic [5*MS-5:0] prod2;
  logic [2*MS-1:0] corr_t, x1;
  assign prod = (4*MS-4)'(num_i) * (4*MS-4)'(x_i);
  assign corr = TWO - prod;
  // correction term keeps one integer bit: it stays below 2 for sane seeds
  assign corr_t = (2*MS)'(corr >> (2*MS-5));
  assign prod2 = (5*MS-4)'(x_i) * (5*MS-4)'(corr_t);
  assign x1 = (2*MS)'(prod2 >> (3*MS-5));
  if (NR_LAT == 0) begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign x1_o = x1;
  end else begin : g_reg
    always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) x1_o <= '0;
      else x1_o <= x1;
  end
endmodule

// File: rtl/nr_sequencer.sv
// nr_sequencer: iterates one shared Newton-Raphson datapath to refine a reciprocal seed
module nr_sequencer
  import ppu_pkg::*;
#(
  parameter int N = `N,
  parameter int ITERS = NR_ITERS,
  parameter int NR_LAT = NR_LAT_DEF,
  localparam int MS = mant_size(N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [MS-1:0]   num_i,
  input  logic [3*MS-5:0] x0_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [2*MS-1:0] x_o,
  output logic            busy_o
);
  nr_state_t state;
  logic [MS-1:0] num_q;
  logic [3*MS-5:0] x_q;
  logic [2*MS-1:0] res_q, x1;
  logic [2:0] iter_cnt;
  logic lat_cnt;
  if (ITERS < 1 || ITERS > 7 || NR_LAT < 0 || NR_LAT > 1) begin : g_bad_param
    $error("nr_sequencer: ITERS must be 1..7 and NR_LAT 0..1");
  end
  newton_raphson #(.MS(MS), .NR_LAT(NR_LAT)) u_nr (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .num_i(num_q),
    .x_i(x_q),
    .x1_o(x1)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      num_q <= '0;
      x_q <= '0;
      res_q <= '0;
      iter_cnt <= '0;
      lat_cnt <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid_i) begin
          num_q <= num_i;
          x_q <= x0_i;
          iter_cnt <= '0;
          lat_cnt <= 1'b0;
          state <= RUN;
        end
        RUN: if (lat_cnt == 1'(NR_LAT)) begin
          if (iter_cnt == 3'(ITERS - 1)) begin
            res_q <= x1;
            state <= DONE;
          end else begin
            x_q <= {x1, {(MS-4){1'b0}}};
            iter_cnt <= iter_cnt + 3'd1;
            lat_cnt <= 1'b0;
          end
        end else lat_cnt <= lat_cnt + 1'b1;
        // res_q is cleared on exit so x_o can be driven straight from it
        DONE: if (out_ready_i) begin
          res_q <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign in_ready_o = state == IDLE;
  assign out_valid_o = state == DONE;
  assign busy_o = state != IDLE;
  assign x_o = res_q;
endmodule

// File: tb/tb_nr_sequencer.sv
// tb_nr_sequencer: scoreboard bench for the reciprocal sequencer
module tb_nr_sequencer;
  import ppu_pkg::*;
  localparam int N = 16;
  localparam int MS = mant_size(N);
  localparam int XW = 3*MS-4;
  localparam int RW = 2*MS;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [MS-1:0] num = '0;
  logic [XW-1:0] x0 = '0;
  logic in_ready, out_valid, busy;
  logic [RW-1:0] x_o;
  logic in_valid1 = 1'b0, flush1 = 1'b0, out_ready1 = 1'b0;
  logic [MS-1:0] num1 = '0;
  logic [XW-1:0] x01 = '0;
  logic in_ready1, out_valid1, busy1;
  logic [RW-1:0] x_o1;
  int checks = 0, errors = 0;
  logic [RW-1:0] exp_q[$];

  always #5 clk = ~clk;

  nr_sequencer #(.N(N), .ITERS(2), .NR_LAT(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .num_i(num), .x0_i(x0), .flush_i(flush), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .x_o(x_o), .busy_o(busy)
  );
  nr_sequencer #(.N(N), .ITERS(1), .NR_LAT(0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
    .num_i(num1), .x0_i(x01), .flush_i(flush1), .out_valid_o(out_valid1),
    .out_ready_i(out_ready1), .x_o(x_o1), .busy_o(busy1)
  );

  // fixed-point reference: x <- x*(2 - n*x), correction kept to 2MS bits, result to 2MS bits
  function automatic logic [RW-1:0] nr_ref(input logic [MS-1:0] n, input logic [XW-1:0] s, input int iters);
    logic [127:0] x, t, r;
    x = 128'(s);
    r = '0;
    for (int i = 0; i < iters; i++) begin
      t = ((128'd2 << (4*MS-6)) - 128'(n) * x) & ((128'd1 << (4*MS-4)) - 128'd1);
      t = (t >> (2*MS-5)) & ((128'd1 << RW) - 128'd1);
      r = ((x * t) >> (3*MS-5)) & ((128'd1 << RW) - 128'd1);
      x = r << (MS-4);
    end
    return r[RW-1:0];
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, x_o} !== {3'b100, RW'(0)}) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b x=%h exp rdy=1 vld=0 busy=0 x=0", in_ready, out_valid, busy, x_o);
    end
    checks++;
    if ({in_ready1, out_valid1, busy1, x_o1} !== {3'b100, RW'(0)}) begin
      errors++;
      $display("FAIL reset_outputs_dut1 got rdy=%b vld=%b busy=%b x=%h exp rdy=1 vld=0 busy=0 x=0", in_ready1, out_valid1, busy1, x_o1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_golden();
    int lat;
    real v;
    logic [RW-1:0] exp_v;
    in_valid = 1'b1;
    num = MS'(3) << (MS-2);
    x0 = XW'(11) << (XW-5);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL golden_accept got rdy=%b exp=1", in_ready); end
    exp_q.push_back(nr_ref(num, x0, 2));
    lat = 0;
    do begin @(negedge clk); in_valid = 1'b0; lat++; end while (out_valid !== 1'b1 && lat < 20);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL golden_latency got=%0d exp=5", lat); end
    exp_v = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
    checks++;
    if (x_o !== exp_v) begin errors++; $display("FAIL golden_model got=%h exp=%h", x_o, exp_v); end
    checks++;
    if (x_o !== (RW'(349525) << (RW-20))) begin errors++; $display("FAIL golden_exact got=%h exp=%h", x_o, RW'(349525) << (RW-20)); end
    v = real'(x_o) / (2.0 ** (RW-1));
    checks++;
    if (v < 0.6657 || v > 0.6677) begin errors++; $display("FAIL golden_approx got=%f exp=0.6667", v); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL golden_busy got=%b exp=1", busy); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, busy, x_o} !== {3'b010, RW'(0)}) begin
      errors++;
      $display("FAIL golden_release got vld=%b rdy=%b busy=%b x=%h exp vld=0 rdy=1 busy=0 x=0", out_valid, in_ready, busy, x_o);
    end
  endtask

  task automatic test_backpressure();
    int lat, seen;
    logic [RW-1:0] held, exp_v;
    in_valid = 1'b1;
    num = MS'(5) << (MS-3);
    x0 = XW'(3) << (XW-3);
    exp_q.push_back(nr_ref(num, x0, 2));
    lat = 0;
    do begin
      @(negedge clk);
      num = MS'(7) << (MS-3);
      x0 = XW'(1) << (XW-2);
      lat++;
    end while (out_valid !== 1'b1 && lat < 20);
    exp_v = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
    checks++;
    if (x_o !== exp_v) begin errors++; $display("FAIL bp_value got=%h exp=%h", x_o, exp_v); end
    held = exp_v;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, x_o} !== {2'b10, held}) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d got vld=%b rdy=%b x=%h exp vld=1 rdy=0 x=%h", i, out_valid, in_ready, x_o, held);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL bp_release got vld=%b rdy=%b busy=%b exp vld=0 rdy=1 busy=0", out_valid, in_ready, busy);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (out_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL bp_phantom got=%0d results exp=0", seen); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    int lat, seen;
    logic [RW-1:0] exp_v;
    in_valid = 1'b1;
    flush = 1'b1;
    num = MS'(5) << (MS-3);
    x0 = XW'(3) << (XW-3);
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_vs_accept got busy=%b exp=0", busy); end
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b010) begin
      errors++;
      $display("FAIL flush_idle got busy=%b rdy=%b vld=%b exp busy=0 rdy=1 vld=0", busy, in_ready, out_valid);
    end
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (out_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush_no_output got=%0d results exp=0", seen); end
    in_valid = 1'b1;
    num = MS'(7) << (MS-3);
    x0 = XW'(1) << (XW-2);
    exp_q.push_back(nr_ref(num, x0, 2));
    lat = 0;
    do begin @(negedge clk); in_valid = 1'b0; lat++; end while (out_valid !== 1'b1 && lat < 20);
    exp_v = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
    checks++;
    if (x_o !== exp_v || lat != 5) begin
      errors++;
      $display("FAIL flush_next_op got x=%h lat=%0d exp x=%h lat=5", x_o, lat, exp_v);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int seen;
    in_valid = 1'b1;
    num = MS'(3) << (MS-2);
    x0 = XW'(11) << (XW-5);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, x_o} !== {3'b100, RW'(0)}) begin
      errors++;
      $display("FAIL async_reset got rdy=%b vld=%b busy=%b x=%h exp rdy=1 vld=0 busy=0 x=0", in_ready, out_valid, busy, x_o);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (out_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL async_reset_stale got=%0d results exp=0", seen); end
    out_ready = 1'b0;
  endtask

  task automatic test_iters1();
    int lat;
    in_valid1 = 1'b1;
    num1 = MS'(1) << (MS-1);
    x01 = XW'(1) << (XW-1);
    out_ready1 = 1'b1;
    lat = 0;
    do begin @(negedge clk); in_valid1 = 1'b0; lat++; end while (out_valid1 !== 1'b1 && lat < 20);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL iters1_latency got=%0d exp=2", lat); end
    checks++;
    if (x_o1 !== (RW'(1) << (RW-1))) begin errors++; $display("FAIL iters1_value got=%h exp=%h", x_o1, RW'(1) << (RW-1)); end
    @(negedge clk);
    checks++;
    if ({out_valid1, in_ready1} !== 2'b01) begin
      errors++;
      $display("FAIL iters1_release got vld=%b rdy=%b exp vld=0 rdy=1", out_valid1, in_ready1);
    end
    out_ready1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc, got, drain;
    logic [RW-1:0] exp_v;
    acc = 0;
    got = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (x_o !== RW'(0) && out_valid !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL b2b_idle_zero cycle=%0d got x=%h exp=0", c, x_o);
      end
      in_valid = ($urandom % 4) != 0;
      num = {1'b1, (MS-1)'($urandom)};
      x0 = {2'b01, (XW-2)'({$urandom, $urandom})};
      out_ready = ($urandom % 3) != 0;
      if (in_valid && in_ready) begin exp_q.push_back(nr_ref(num, x0, 2)); acc++; end
      if (out_valid && out_ready) begin
        exp_v = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        got++;
        checks++;
        if (x_o !== exp_v) begin errors++; $display("FAIL b2b_result n=%0d got=%h exp=%h", got, x_o, exp_v); end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain = 0;
    while (exp_q.size() != 0 && drain < 60) begin
      @(negedge clk);
      drain++;
      if (out_valid) begin
        exp_v = exp_q.pop_front();
        got++;
        checks++;
        if (x_o !== exp_v) begin errors++; $display("FAIL b2b_drain n=%0d got=%h exp=%h", got, x_o, exp_v); end
      end
    end
    checks++;
    if (exp_q.size() != 0 || acc != got || acc == 0) begin
      errors++;
      $display("FAIL b2b_count got results=%0d pending=%0d exp results=%0d pending=0", got, exp_q.size(), acc);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_golden();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_iters1();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nr_sequencer.md
NR_SEQUENCER -- requirements
Module: nr_sequencer

Interface
REQ-001 SHALL have parameter N, default `N: posit width; MS taken from ppu_pkg.
REQ-002 SHALL have parameter ITERS, default 2: Newton-Raphson iterations per operation, legal range 1..7.
REQ-003 SHALL have parameter NR_LAT, default 1 if PIPELINE_STAGE is defined, else 0: latency of the iteration datapath in cycles.
REQ-004 SHALL have port clk_i, input, 1: the single clock.
REQ-005 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid_i, input, 1: operand valid.
REQ-007 SHALL have port in_ready_o, output, 1: the block can accept an operand.
REQ-008 SHALL have port num_i, input, MS: divisor mantissa, Fx<1,MS>.
REQ-009 SHALL have port x0_i, input, 3*MS-4: initial reciprocal seed, Fx<1,3MS-4>.
REQ-010 SHALL have port flush_i, input, 1: synchronous abort of the current operation.
REQ-011 SHALL have port out_valid_o, output, 1: result valid.
REQ-012 SHALL have port out_ready_i, input, 1: consumer accepts the result.
REQ-013 SHALL have port x_o, output, 2*MS: refined reciprocal, Fx<1,2MS>.
REQ-014 SHALL have port busy_o, output, 1: the FSM is not in IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-016 SHALL drive in_ready_o=1 only in IDLE; an input handshake is in_valid_i & in_ready_o.
REQ-017 On an input handshake, SHALL latch num_i into num_q and x0_i into x_q, clear iter_cnt and lat_cnt, and go to RUN.
REQ-018 In RUN, SHALL drive the datapath with num_q and x_q, held stable for NR_LAT+1 cycles per iteration, counted by lat_cnt.
REQ-019 SHALL sample the datapath output x1 in the final cycle of each iteration (lat_cnt==NR_LAT).
REQ-020 At each sample where iter_cnt<ITERS-1, SHALL load x_q with x1 zero-extended and left-shifted by MS-4 (exact width 3MS-4, no truncation), increment iter_cnt and clear lat_cnt.
REQ-021 At the sample where iter_cnt==ITERS-1, SHALL load res_q with x1 and go to DONE.
REQ-022 SHALL drive out_valid_o=1 and x_o=res_q in DONE only; x_o SHALL hold res_q until the output handshake.
REQ-023 On out_valid_o & out_ready_i, SHALL go from DONE to IDLE; a new input is accepted no earlier than the following cycle.
REQ-024 SHALL raise out_valid_o exactly ITERS*(NR_LAT+1)+1 cycles after the input-handshake cycle; this is the latency.
REQ-025 flush_i=1 in any state SHALL force IDLE on the next edge, discard res_q and produce no out_valid_o pulse.
REQ-026 flush_i SHALL take priority over a coincident input or output handshake.
REQ-027 In DONE with out_ready_i=0, SHALL hold state and x_o indefinitely (backpressure).
REQ-028 SHALL tie x_o to 0 whenever out_valid_o=0.
REQ-029 SHALL drive busy_o=1 in RUN and DONE.

Reset
REQ-030 rst_i=1 SHALL asynchronously force IDLE, clear num_q, x_q, res_q, iter_cnt and lat_cnt, and set in_ready_o=1, out_valid_o=0, x_o=0, busy_o=0.
REQ-031 Reset asserted mid-RUN or in DONE SHALL abandon the operation with no output pulse after release.
REQ-032 SHALL propagate rst_i to the datapath instance.

Structure
REQ-033 SHALL place nr_state_t (IDLE, RUN, DONE) and the ITERS default constant NR_ITERS in ppu_pkg.
REQ-034 SHALL instantiate exactly one newton_raphson sub-module as the shared iteration datapath; no second multiplier.
REQ-035 SHALL size iter_cnt to 3 bits and lat_cnt to 1 bit.
REQ-036 SHALL fail at elaboration on ITERS outside 1..7 or NR_LAT outside 0..1.

Verification
REQ-037 N=16, ITERS=2, NR_LAT=1, num=1.5, x0=0.6875 -> out_valid_o at cycle 5; x_o equals the bit-exact golden model and approximates 0.6667.
REQ-038 ITERS=1, NR_LAT=0, num=1.0, x0=1.0 -> out_valid_o 2 cycles after accept; x_o=1.0 exactly.
REQ-039 Hold out_ready_i=0 for 10 cycles in DONE -> x_o stable, in_ready_o=0, no new operand accepted; out_ready_i=1 -> IDLE the next cycle.
REQ-040 flush_i pulse in the 2nd RUN cycle -> IDLE next edge, no out_valid_o; a following operand yields the correct result.
REQ-041 Assert rst_i asynchronously mid-RUN -> all outputs reach reset values before the next edge; no stale result after release.
REQ-042 Random back-to-back operands with random out_ready_i -> every accepted operand produces exactly one result, in order, matching the golden model.
